rat_register_file: RTL and testbench
====================================

// Module: rat_register_file
// PURPOSE
// - General-purpose register file for the 8-bit RAT-style CPU datapath: 32 x 8-bit registers.
// - Two combinational read ports (X, Y); one synchronous write port that shares the X address.
// - Sits between the instruction decoder (ADRX/ADRY from IR fields) and the ALU operand
//   muxes; DIN arrives from the result mux, RF_WR from the control unit.
// PARAMETERS
// - DATA_W  default 8   register/data width in bits
// - ADDR_W  default 5   address width; DEPTH = 2**ADDR_W (32) registers
// PORTS
// - clk     in   1       system clock; all state changes on the rising edge
// - rst     in   1       synchronous, active-high reset
// - DIN     in   DATA_W  write data
// - ADRX    in   ADDR_W  read-port-X address, also the write address
// - ADRY    in   ADDR_W  read-port-Y address
// - RF_WR   in   1       write enable
// - DX_OUT  out  DATA_W  contents of register[ADRX]
// - DY_OUT  out  DATA_W  contents of register[ADRY]
// BEHAVIOUR
// - Interface: one clock (clk); reset rst is synchronous and active-high.
// - Reset: at posedge clk with rst=1, all DEPTH registers are cleared to 0.
//   rst has priority over RF_WR; a write in the reset cycle is discarded.
//   After the reset edge, DX_OUT = DY_OUT = 0 for every address.
// - Write: at posedge clk with rst=0 and RF_WR=1, register[ADRX] <= DIN.
//   Latency 1 edge; visible on the read ports immediately after that edge.
// - RF_WR=0: no register changes; DIN is ignored.
// - Read: DX_OUT/DY_OUT are purely combinational from the register array and the
//   addresses (zero-cycle latency); there is no output register and no enable.
// - ADRX == ADRY: both ports return the same register value.
// - Same-cycle read of the register being written (base build): the read returns the OLD
//   value until the edge, then the new value.
// - No out-of-range addresses exist (DEPTH = 2**ADDR_W); no register is hard-wired to 0.
// - No X-propagation: every register has a defined value after the first reset.
// CONFIGURATION
// - Macro RF_BYPASS_EN:
//   defined     -> write-through bypass: while RF_WR=1 and rst=0, any read port whose
//                  address equals ADRX drives DIN combinationally; otherwise the array value.
//   not defined -> no bypass; reads always return the stored array value (base build).
// - Register-update timing and reset behaviour are identical in both builds.
// STRUCTURE
// - Package rf_pkg: localparams RF_DATA_W=8, RF_ADDR_W=5, RF_DEPTH=32;
//   typedefs rf_data_t = logic [RF_DATA_W-1:0], rf_addr_t = logic [RF_ADDR_W-1:0].
// - Sub-module rf_read_port: one combinational read mux, instantiated twice (X, Y).
//   Optional bypass compare lives inside it (inputs: array, addr, wr_addr, DIN, wr_en).
// - Top level holds the register array plus the reset/write always_ff.
// TESTING
// - Reset: rst=1 for one edge, then sweep ADRX/ADRY 0..31 -> DX_OUT=DY_OUT=0 everywhere.
// - Basic write/read: DIN=4, ADRX=1, RF_WR=1, one edge; then DIN=9, ADRX=3, ADRY=1
//   -> DY_OUT=4; after the next edge, ADRY=3 -> DY_OUT=9.
// - Write disabled: DIN=33, ADRX=1, RF_WR=0, one edge -> DX_OUT stays 4.
// - Read-during-write: ADRX=ADRY=3 (r3=9), DIN=33, RF_WR=1 -> before the edge
//   DX_OUT=DY_OUT=9 (base) or 33 (RF_BYPASS_EN); after the edge, 33 in both builds.
// - Sweep: for i=0..31, DIN=i, ADRX=i, ADRY=31-i, RF_WR=1, one edge each
//   -> afterwards register[i]=i for all i; read back all 32 on both ports.
// - Reset priority: rst=1, RF_WR=1, DIN=8'hAA, ADRX=5 -> after the edge, r5=0, not 8'hAA.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared sizing and types for the RAT register file.
// The optional write-through bypass is selected by the RF_BYPASS_EN macro.
package rf_pkg;

  localparam int RF_DATA_W = 8;
  localparam int RF_ADDR_W = 5;
  localparam int RF_DEPTH  = 2 ** RF_ADDR_W;

  typedef logic [RF_DATA_W-1:0] rf_data_t;
  typedef logic [RF_ADDR_W-1:0] rf_addr_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read mux of the register file.
// The RF_BYPASS_EN macro adds forwarding of in-flight write data.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic [2**ADDR_W-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]                addr,
  input  logic [ADDR_W-1:0]                wr_addr,
  input  logic [DATA_W-1:0]                wr_data,
  input  logic                             wr_en,
  output logic [DATA_W-1:0]                rd_data
);

`ifdef RF_BYPASS_EN
  // A write to the addressed register shows its data before the clock edge.
  always_comb begin
    rd_data = regs[addr];
    if (wr_en && (addr == wr_addr)) begin
      rd_data = wr_data;
    end
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{wr_addr, wr_data, wr_en};

  always_comb begin
    rd_data = regs[addr];
  end
`endif

endmodule

// File: rtl/rat_register_file.sv
// 32 x 8 register file: two combinational read ports, one synchronous write port on ADRX.
// Build with RF_BYPASS_EN to forward write data to matching read ports.
module rat_register_file
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] DIN,
  input  logic [ADDR_W-1:0] ADRX,
  input  logic [ADDR_W-1:0] ADRY,
  input  logic              RF_WR,
  output logic [DATA_W-1:0] DX_OUT,
  output logic [DATA_W-1:0] DY_OUT
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] regs_q;
  logic [DEPTH-1:0][DATA_W-1:0] regs_d;
  logic                         wr_live;

  always_comb begin
    regs_d = regs_q;
    if (RF_WR) begin
      regs_d[ADRX] = DIN;
    end
  end

  // Reset wins over a write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign wr_live = RF_WR & ~rst;

  rf_read_port #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_port_x (
    .regs   (regs_q),
    .addr   (ADRX),
    .wr_addr(ADRX),
    .wr_data(DIN),
    .wr_en  (wr_live),
    .rd_data(DX_OUT)
  );

  rf_read_port #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_port_y (
    .regs   (regs_q),
    .addr   (ADRY),
    .wr_addr(ADRX),
    .wr_data(DIN),
    .wr_en  (wr_live),
    .rd_data(DY_OUT)
  );

endmodule

// File: tb/tb_rat_register_file.sv
// Randomized scoreboard bench for rat_register_file against a plain array model.
// Define RF_BYPASS_EN for both RTL and bench to check the bypass build.
module tb_rat_register_file;
  import rf_pkg::*;

`ifdef RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic     clk;
  logic     rst;
  rf_data_t din;
  rf_addr_t adrx;
  rf_addr_t adry;
  logic     rf_wr;
  rf_data_t dx_out;
  rf_data_t dy_out;

  rat_register_file dut (
    .clk   (clk),
    .rst   (rst),
    .DIN   (din),
    .ADRX  (adrx),
    .ADRY  (adry),
    .RF_WR (rf_wr),
    .DX_OUT(dx_out),
    .DY_OUT(dy_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model and scoreboard
  rf_data_t              model[RF_DEPTH];
  logic [RF_DATA_W-1:0]  exp_x_q[$];
  logic [RF_DATA_W-1:0]  exp_y_q[$];
  int                    errors = 0;
  int                    checks = 0;
  int                    cyc    = 0;

  function automatic rf_data_t expect_read(input rf_addr_t a);
    if (BYPASS && !rst && rf_wr && (a == adrx)) return din;
    return model[a];
  endfunction

  // monitor: outputs are combinational, so compare mid-cycle
  always @(negedge clk) begin
    while (exp_x_q.size() > 0) begin
      logic [RF_DATA_W-1:0] e;
      e = exp_x_q.pop_front();
      checks++;
      if (dx_out !== e) begin
        errors++;
        $display("FAIL dx_out cyc=%0d adrx=%0d: got %h expected %h", cyc, adrx, dx_out, e);
      end
    end
    while (exp_y_q.size() > 0) begin
      logic [RF_DATA_W-1:0] e;
      e = exp_y_q.pop_front();
      checks++;
      if (dy_out !== e) begin
        errors++;
        $display("FAIL dy_out cyc=%0d adry=%0d: got %h expected %h", cyc, adry, dy_out, e);
      end
    end
  end

  // driver: called just after a rising edge; applies inputs for one full cycle
  task automatic step(input logic r, input logic w, input rf_data_t d,
                      input rf_addr_t ax, input rf_addr_t ay);
    rst   = r;
    rf_wr = w;
    din   = d;
    adrx  = ax;
    adry  = ay;
    exp_x_q.push_back(expect_read(ax));
    exp_y_q.push_back(expect_read(ay));
    @(posedge clk);
    if (r) begin
      foreach (model[i]) model[i] = '0;
    end else if (w) begin
      model[ax] = d;
    end
    cyc++;
    #1;
  endtask

  task automatic sweep_read();
    for (int i = 0; i < RF_DEPTH; i++) begin
      step(1'b0, 1'b0, rf_data_t'($urandom), rf_addr_t'(i), rf_addr_t'(RF_DEPTH - 1 - i));
    end
  endtask

  initial begin
    rst   = 1'b1;
    rf_wr = 1'b0;
    din   = '0;
    adrx  = '0;
    adry  = '0;
    @(posedge clk);
    foreach (model[i]) model[i] = '0;
    #1;

    // reset contents
    sweep_read();

    // basic write then read
    step(1'b0, 1'b1, 8'd4, 5'd1, 5'd0);
    step(1'b0, 1'b1, 8'd9, 5'd3, 5'd1);
    step(1'b0, 1'b0, 8'd0, 5'd0, 5'd3);

    // write disabled
    step(1'b0, 1'b0, 8'd33, 5'd1, 5'd1);
    step(1'b0, 1'b0, 8'd0, 5'd1, 5'd2);

    // read during write, same address on both ports
    step(1'b0, 1'b1, 8'd33, 5'd3, 5'd3);
    step(1'b0, 1'b0, 8'd0, 5'd3, 5'd3);

    // write sweep, then read back
    for (int i = 0; i < RF_DEPTH; i++) begin
      step(1'b0, 1'b1, rf_data_t'(i), rf_addr_t'(i), rf_addr_t'(RF_DEPTH - 1 - i));
    end
    sweep_read();

    // reset priority over a write
    step(1'b1, 1'b1, 8'hAA, 5'd5, 5'd5);
    step(1'b0, 1'b0, 8'h00, 5'd5, 5'd5);

    // random traffic with occasional reset
    for (int n = 0; n < 400; n++) begin
      logic r;
      logic w;
      rf_addr_t ax;
      rf_addr_t ay;
      r  = ($urandom_range(0, 49) == 0);
      w  = ($urandom_range(0, 2) != 0);
      ax = rf_addr_t'($urandom_range(0, RF_DEPTH - 1));
      ay = ($urandom_range(0, 3) == 0) ? ax : rf_addr_t'($urandom_range(0, RF_DEPTH - 1));
      step(r, w, rf_data_t'($urandom), ax, ay);
    end
    sweep_read();

    @(negedge clk);
    #1;
    checks++;
    if ((exp_x_q.size() + exp_y_q.size()) != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0",
               exp_x_q.size() + exp_y_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
